icache_line_fill: RTL and testbench
===================================

ICACHE_LINE_FILL -- requirements
Module: icache_line_fill

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning bus word width in bits.
REQ-002 The block SHALL have parameter CLSIZE, default `CLP, meaning cache line width in bits; BEATS = CLSIZE/XLEN, a power of 2, at least 2.
REQ-003 clk_i  input  1  sole clock, all state on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 c_strobe_i  input  1  line-read request from I-cache, held high until c_ready_o is seen.
REQ-006 c_addr_i  input  XLEN  line address, sampled on acceptance.
REQ-007 c_ready_o  output  1  one-cycle pulse: c_data_o holds a complete line.
REQ-008 c_data_o  output  CLSIZE  assembled line, word 0 at bits [CLSIZE-1 -: XLEN].
REQ-009 b_req_o  output  1  bus read address valid.
REQ-010 b_addr_o  output  XLEN  bus word address.
REQ-011 b_gnt_i  input  1  address accepted when b_req_o && b_gnt_i.
REQ-012 b_rvalid_i  input  1  read data beat valid; beats return in issue order, no earlier than the cycle after their grant.
REQ-013 b_rdata_i  input  XLEN  read data beat.

Function
REQ-014 States SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-015 IDLE: c_strobe_i high -> latch {c_addr_i[XLEN-1:WORD_BITS+2], zeros} as line base, clear both counters, go ISSUE.
REQ-016 ISSUE: b_req_o = 1, b_addr_o = base + 4*issue_cnt; issue_cnt increments on each grant; grant with issue_cnt = BEATS-1 -> WAIT, or DONE if the final beat is captured in that same cycle.
REQ-017 b_req_o and b_addr_o SHALL hold stable while b_req_o && !b_gnt_i.
REQ-018 Each b_rvalid_i in ISSUE or WAIT SHALL write b_rdata_i to c_data_o[CLSIZE-1-XLEN*data_cnt -: XLEN] and increment data_cnt.
REQ-019 A grant and a data beat in the same cycle SHALL both be processed.
REQ-020 Capture of beat BEATS-1 SHALL move to DONE; c_ready_o = 1 exactly for the DONE cycle; DONE -> IDLE unconditionally.
REQ-021 c_strobe_i seen in DONE SHALL be ignored; a new request is accepted only in IDLE.
REQ-022 c_data_o SHALL remain stable from the DONE cycle until the first beat of the next fill.
REQ-023 b_rvalid_i in IDLE or DONE SHALL be ignored.
REQ-024 b_req_o = 0 and b_addr_o = 0 in every state except ISSUE.
REQ-025 Latency with grant every cycle and 1-cycle data: request in IDLE at cycle 0; grants at cycles 1..BEATS; c_ready_o at cycle BEATS+2.
REQ-026 Counters SHALL be $clog2(BEATS) bits wide and SHALL NOT wrap within a fill; the address add wraps modulo 2^XLEN.

Reset
REQ-027 rst_ni low SHALL immediately force IDLE, clear counters, base and c_data_o, and drive c_ready_o = 0, b_req_o = 0, b_addr_o = 0.
REQ-028 Reset mid-fill SHALL abandon the fill; its late beats SHALL be ignored by REQ-023.

Structure
REQ-029 CLP and XLEN SHALL come from aquila_config.vh; BEATS, WORD_BITS and the state encoding SHALL be module localparams.
REQ-030 No sub-module is needed: one FSM, two counters, one line register.

Verification
REQ-031 CLSIZE=128, request addr 0x0000_1234, gnt always 1, rdata 0xA0,0xA1,0xA2,0xA3 at 1-cycle latency -> b_addr 0x1230,0x1234,0x1238,0x123C; c_ready_o at cycle 6; c_data_o = {A0,A1,A2,A3}.
REQ-032 Same, but gnt low for 3 cycles on beat 1 -> b_addr held at 0x1234 for all 3 cycles; line data correct; c_ready_o delayed 3 cycles.
REQ-033 Data 5 cycles after each grant, beats overlapping later grants -> all 4 words captured in order; single c_ready_o pulse.
REQ-034 rst_ni low after 2 grants, released, 2 stale rvalids, then a new request to 0x2000 -> stale beats ignored; new line = exactly the 4 new beats.
REQ-035 c_strobe_i held high through DONE -> exactly one fill and one c_ready_o pulse.
REQ-036 Request at 0xFFFF_FFF0 -> b_addr 0xFFFFFFF0..0xFFFFFFFC; c_ready_o asserted after beat 3.

Source files
------------

// File: rtl/icache_line_fill_pkg.sv
// Shared configuration and FSM state type for the I-cache line-fill engine.
package icache_line_fill_pkg;

  localparam int unsigned CFG_XLEN = 32;
  localparam int unsigned CLP      = 128;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } fill_state_t;

endpackage

// File: rtl/icache_line_fill.sv
// Fetches one cache line as BEATS bus words, issuing addresses and collecting
// in-order read beats into a line register presented to the I-cache.
module icache_line_fill
  import icache_line_fill_pkg::*;
#(
  parameter int unsigned XLEN   = CFG_XLEN,
  parameter int unsigned CLSIZE = CLP
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              c_strobe_i,
  input  logic [XLEN-1:0]   c_addr_i,
  output logic              c_ready_o,
  output logic [CLSIZE-1:0] c_data_o,
  output logic              b_req_o,
  output logic [XLEN-1:0]   b_addr_o,
  input  logic              b_gnt_i,
  input  logic              b_rvalid_i,
  input  logic [XLEN-1:0]   b_rdata_i
);

  localparam int unsigned BEATS     = CLSIZE / XLEN;
  localparam int unsigned WORD_BITS = $clog2(BEATS);
  localparam logic [WORD_BITS-1:0] LAST     = WORD_BITS'(BEATS - 1);
  localparam logic [XLEN-1:0]      OFS_MASK = XLEN'(BEATS * 4 - 1);

  fill_state_t           r_state, w_next_state;
  logic [WORD_BITS-1:0]  r_issue_cnt, r_data_cnt;
  logic [XLEN-1:0]       r_base;
  logic [CLSIZE-1:0]     r_data;
  logic                  w_grant, w_beat, w_last_beat;

  assign w_grant     = (r_state == S_ISSUE) && b_gnt_i;
  assign w_beat      = ((r_state == S_ISSUE) || (r_state == S_WAIT)) && b_rvalid_i;
  assign w_last_beat = w_beat && (r_data_cnt == LAST);

  always_comb begin
    w_next_state = r_state;
    c_ready_o    = 1'b0;
    b_req_o      = 1'b0;
    b_addr_o     = '0;
    case (r_state)
      S_IDLE:  if (c_strobe_i) w_next_state = S_ISSUE;
      S_ISSUE: begin
        b_req_o  = 1'b1;
        b_addr_o = r_base + XLEN'({r_issue_cnt, 2'b00});
        if (w_last_beat)                            w_next_state = S_DONE;
        else if (w_grant && (r_issue_cnt == LAST)) w_next_state = S_WAIT;
      end
      S_WAIT:  if (w_last_beat) w_next_state = S_DONE;
      S_DONE: begin
        c_ready_o    = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Counters saturate at LAST instead of wrapping; the state change ends the fill.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_issue_cnt <= '0;
      r_data_cnt  <= '0;
      r_base      <= '0;
      r_data      <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_IDLE) && c_strobe_i) begin
        r_base      <= c_addr_i & ~OFS_MASK;
        r_issue_cnt <= '0;
        r_data_cnt  <= '0;
      end
      if (w_grant && (r_issue_cnt != LAST))
        r_issue_cnt <= r_issue_cnt + WORD_BITS'(1);
      if (w_beat) begin
        for (int unsigned i = 0; i < BEATS; i++) begin
          if (r_data_cnt == WORD_BITS'(i))
            r_data[CLSIZE-1-XLEN*i -: XLEN] <= b_rdata_i;
        end
        if (r_data_cnt != LAST)
          r_data_cnt <= r_data_cnt + WORD_BITS'(1);
      end
    end
  end

  assign c_data_o = r_data;

endmodule

// File: tb/tb_icache_line_fill.sv
// Randomized scoreboard bench for icache_line_fill with a modelled memory and bus.
module tb_icache_line_fill;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         c_strobe;
  logic [31:0]  c_addr;
  logic         c_ready_o;
  logic [127:0] c_data_o;
  logic         b_req_o;
  logic [31:0]  b_addr_o;
  logic         b_gnt;
  logic         b_rvalid;
  logic [31:0]  b_rdata;

  int unsigned n_pass = 0, n_total = 0;
  int unsigned cyc = 0, ready_cnt = 0, grants_done = 0;
  int unsigned gnt_pct = 100, lat_min = 1, lat_max = 1, hold_beat = 0, hold_left = 0;
  time         t_start;
  int unsigned rc0;

  logic [31:0]  mem [logic [31:0]];
  logic [31:0]  exp_addr_q [$];
  logic [127:0] exp_line_q [$];
  int unsigned  due_q [$];
  logic [31:0]  dat_q [$];

  icache_line_fill #(.XLEN(32), .CLSIZE(128)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .c_strobe_i(c_strobe), .c_addr_i(c_addr),
    .c_ready_o(c_ready_o), .c_data_o(c_data_o),
    .b_req_o(b_req_o), .b_addr_o(b_addr_o), .b_gnt_i(b_gnt),
    .b_rvalid_i(b_rvalid), .b_rdata_i(b_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Bus slave model plus output monitor, all at the falling edge.
  always @(negedge clk) begin : mon
    int unsigned lat;
    cyc++;
    if (b_req_o) begin
      if (exp_addr_q.size() == 0) check("unexpected_req", b_req_o, 0);
      else check("b_addr", b_addr_o, exp_addr_q[0]);
    end else begin
      check("b_addr_idle", b_addr_o, 0);
    end
    if (c_ready_o) begin
      ready_cnt++;
      if (exp_line_q.size() == 0) check("unexpected_ready", c_ready_o, 0);
      else check("line", c_data_o, exp_line_q.pop_front());
    end
    if (b_req_o && hold_left > 0 && grants_done == hold_beat) begin
      b_gnt = 1'b0;
      hold_left--;
    end else begin
      b_gnt = ($urandom_range(99) < gnt_pct);
    end
    if (b_req_o && b_gnt) begin
      lat = $urandom_range(lat_max, lat_min);
      due_q.push_back(cyc + lat);
      dat_q.push_back(mem.exists(b_addr_o) ? mem[b_addr_o] : 32'hDEAD_BEEF);
      grants_done++;
      if (exp_addr_q.size() > 0) void'(exp_addr_q.pop_front());
    end
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      b_rvalid = 1'b1;
      b_rdata  = dat_q.pop_front();
      void'(due_q.pop_front());
    end else begin
      b_rvalid = 1'b0;
      b_rdata  = $urandom;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_fill(input logic [31:0] a, input logic [127:0] d);
    logic [31:0]  base;
    logic [127:0] line;
    base = a & ~32'hF;
    line = '0;
    for (int i = 0; i < 4; i++) begin
      mem[base + 32'(4 * i)] = d[127-32*i -: 32];
      exp_addr_q.push_back(base + 32'(4 * i));
    end
    for (int i = 0; i < 4; i++) line = (line << 32) | 128'(mem[base + 32'(4 * i)]);
    exp_line_q.push_back(line);
    grants_done = 0;
    rc0         = ready_cnt;
    c_addr      = a;
    c_strobe    = 1'b1;
    t_start     = $time;
  endtask

  task automatic wait_ready(input int unsigned extra, output time t_done);
    t_done = 0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (c_ready_o) begin
        t_done = $time;
        break;
      end
    end
    check("ready_seen", t_done != 0, 1);
    if (t_done == 0) begin
      exp_line_q.delete();
      exp_addr_q.delete();
    end
    repeat (extra) tick();
    c_strobe = 1'b0;
  endtask

  initial begin
    time          t;
    logic [127:0] rline;
    rst_n = 1'b0; c_strobe = 1'b0; c_addr = '0;
    b_gnt = 1'b0; b_rvalid = 1'b0; b_rdata = '0;
    #1;
    check("rst_req", b_req_o, 0);
    check("rst_addr", b_addr_o, 0);
    check("rst_ready", c_ready_o, 0);
    check("rst_data", c_data_o, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Basic fill, grant every cycle, one-cycle data.
    start_fill(32'h0000_1234, 128'h000000A0_000000A1_000000A2_000000A3);
    wait_ready(0, t);
    check("lat_basic", t - t_start, 60);
    repeat (3) tick();
    check("pulses_basic", ready_cnt - rc0, 1);
    check("hold_basic", c_data_o, 128'h000000A0_000000A1_000000A2_000000A3);

    // Grant withheld three cycles on beat 1.
    hold_beat = 1; hold_left = 3;
    start_fill(32'h0000_1234, 128'h000000B0_000000B1_000000B2_000000B3);
    wait_ready(0, t);
    check("lat_stall", t - t_start, 90);
    tick();

    // Five-cycle data latency overlapping later grants.
    lat_min = 5; lat_max = 5;
    start_fill(32'h0000_4440, {$urandom, $urandom, $urandom, $urandom});
    wait_ready(0, t);
    check("lat_slow", t - t_start, 100);
    repeat (3) tick();
    check("pulses_slow", ready_cnt - rc0, 1);

    // Reset after two grants; late beats must be ignored.
    lat_min = 3; lat_max = 3;
    start_fill(32'h0000_5000, {$urandom, $urandom, $urandom, $urandom});
    for (int k = 0; k < 50 && grants_done < 2; k++) tick();
    check("two_grants", grants_done, 2);
    rst_n = 1'b0;
    c_strobe = 1'b0;
    exp_addr_q.delete();
    void'(exp_line_q.pop_back());
    #1;
    check("mid_rst_req", b_req_o, 0);
    check("mid_rst_addr", b_addr_o, 0);
    check("mid_rst_ready", c_ready_o, 0);
    check("mid_rst_data", c_data_o, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 30 && due_q.size() > 0; k++) tick();
    check("stale_drained", due_q.size(), 0);
    tick();
    check("stale_ignored", c_data_o, 0);
    lat_min = 1; lat_max = 1;
    start_fill(32'h0000_2000, 128'h11111111_22222222_33333333_44444444);
    wait_ready(0, t);
    check("lat_after_rst", t - t_start, 60);
    tick();

    // Strobe kept high through DONE must not start a second fill.
    start_fill(32'h0000_3000, {$urandom, $urandom, $urandom, $urandom});
    wait_ready(1, t);
    repeat (5) tick();
    check("pulses_held", ready_cnt - rc0, 1);
    check("idle_after_held", b_req_o, 0);

    // Top-of-memory line.
    start_fill(32'hFFFF_FFF0, {$urandom, $urandom, $urandom, $urandom});
    wait_ready(0, t);
    check("lat_top", t - t_start, 60);
    tick();

    // Randomized traffic.
    for (int n = 0; n < 16; n++) begin
      gnt_pct = $urandom_range(100, 30);
      lat_max = $urandom_range(6, 1);
      rline   = {$urandom, $urandom, $urandom, $urandom};
      start_fill($urandom, rline);
      wait_ready($urandom_range(1, 0), t);
      repeat ($urandom_range(3, 1)) tick();
      check("rand_pulses", ready_cnt - rc0, 1);
      check("rand_hold", c_data_o, rline);
    end

    repeat (10) tick();
    check("lines_left", exp_line_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
